// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : conv_pkg
//  Purpose  : Shared widths, FSM state encoding and the shift/saturate helper
//             for the 3x3 convolver lane.
//  Revision : 1.0 - initial release
// ============================================================================
package conv_pkg;

    localparam int BITS_IMAGEN_DEF = 8;
    localparam int BITS_COEF_DEF   = 8;
    localparam int BITS_DATA_DEF   = 13;
    localparam int SHIFT_DEF       = 7;

    // Product of a zero-extended pixel and a signed coefficient, and the
    // width of the full nine-term sum for the default pixel/coef widths.
    localparam int PROD_W = BITS_IMAGEN_DEF + BITS_COEF_DEF + 1;
    localparam int ACC_W  = PROD_W + 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // Arithmetic right shift, then clamp into a signed 'bits'-wide range.
    function automatic logic signed [31:0] sat_shift(
        input logic signed [31:0] sum,
        input int                 shift,
        input int                 bits
    );
        logic signed [31:0] sh;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        sh = sum >>> shift;
        hi = (32'sd1 <<< (bits - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (sh > hi) begin
            return hi;
        end else if (sh < lo) begin
            return lo;
        end
        return sh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_row_mac.sv
`default_nettype none
// ============================================================================
//  Module   : conv_row_mac
//  Purpose  : One kernel row: three pixel x coefficient products (S1) and
//             their sum (S2), both registered.
//  Revision : 1.0 - initial release
// ============================================================================
module conv_row_mac
    import conv_pkg::*;
#(
    parameter int BITS_IMAGEN = BITS_IMAGEN_DEF,
    parameter int BITS_COEF   = BITS_COEF_DEF
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [3*BITS_IMAGEN-1:0]              i_pix,   // tap c at [c*BITS_IMAGEN +: BITS_IMAGEN]
    input  logic [3*BITS_COEF-1:0]                i_coef,  // tap c at [c*BITS_COEF +: BITS_COEF]
    output logic signed [BITS_IMAGEN+BITS_COEF+2:0] o_sum
);

    localparam int MUL_W  = BITS_IMAGEN + BITS_COEF + 1;
    localparam int RSUM_W = MUL_W + 2;

    logic signed [MUL_W-1:0]  prod_d [3];
    logic signed [MUL_W-1:0]  prod_q [3];
    logic signed [RSUM_W-1:0] sum_d;
    logic signed [RSUM_W-1:0] sum_q;

    for (genvar c = 0; c < 3; c++) begin : g_tap
        logic signed [MUL_W-1:0] px_ext;
        logic signed [MUL_W-1:0] cf_ext;
        // Pixels are unsigned: zero-extend so they stay positive in signed math.
        assign px_ext = $signed({{(MUL_W-BITS_IMAGEN){1'b0}}, i_pix[c*BITS_IMAGEN +: BITS_IMAGEN]});
        assign cf_ext = $signed({{(MUL_W-BITS_COEF){i_coef[c*BITS_COEF+BITS_COEF-1]}},
                                 i_coef[c*BITS_COEF +: BITS_COEF]});
        assign prod_d[c] = px_ext * cf_ext;
    end

    assign sum_d = RSUM_W'(prod_q[0]) + RSUM_W'(prod_q[1]) + RSUM_W'(prod_q[2]);

    // S1 product registers and S2 row-sum register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < 3; c++) begin
                prod_q[c] <= '0;
            end
            sum_q <= '0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                prod_q[c] <= prod_d[c];
            end
            sum_q <= sum_d;
        end
    end

    assign o_sum = sum_q;

endmodule
`default_nettype wire

// File: rtl/conv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : conv_unit
//  Purpose  : One 3x3 convolver lane: 3-column sliding window, fill/run FSM,
//             three row MACs, final adder with shift and saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module conv_unit
    import conv_pkg::*;
#(
    parameter int BITS_IMAGEN = BITS_IMAGEN_DEF,
    parameter int BITS_COEF   = BITS_COEF_DEF,
    parameter int BITS_DATA   = BITS_DATA_DEF,
    parameter int SHIFT       = SHIFT_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3*BITS_IMAGEN-1:0] i_col,
    input  logic                     i_valid,
    input  logic                     i_sop,
    input  logic [9*BITS_COEF-1:0]   i_kernel,
    input  logic                     i_kload,
    output logic [BITS_DATA-1:0]     o_data,
    output logic                     o_valid
);

    localparam int MUL_W  = BITS_IMAGEN + BITS_COEF + 1;
    localparam int RSUM_W = MUL_W + 2;
    localparam int TOT_W  = MUL_W + 4;

    state_e                   state_q, state_d;
    logic [1:0]               cnt_q, cnt_d;
    logic                     issue;
    logic [3*BITS_IMAGEN-1:0] win_q [3];
    logic [9*BITS_COEF-1:0]   kern_q;
    logic [9*BITS_COEF-1:0]   kiss_q;   // kernel snapshot travelling with the issued window
    logic                     iss_q, v1_q, v2_q, o_valid_q;
    logic [BITS_DATA-1:0]     o_data_q;
    logic signed [RSUM_W-1:0] row_sum [3];
    logic signed [TOT_W-1:0]  total;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: i_sop always restarts the fill; a valid column with it counts as first.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        issue   = 1'b0;
        if (i_sop) begin
            state_d = ST_FILL;
            cnt_d   = i_valid ? 2'd1 : 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_valid) begin
                        state_d = ST_FILL;
                        cnt_d   = 2'd1;
                    end
                end
                ST_FILL: begin
                    if (i_valid) begin
                        if (cnt_q == 2'd2) begin
                            state_d = ST_RUN;
                            cnt_d   = 2'd0;
                            issue   = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 2'd1;
                        end
                    end
                end
                ST_RUN: begin
                    issue = i_valid;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 2'd0;
                end
            endcase
        end
    end

    // Window shift, kernel latch/snapshot, valid pipeline and output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                win_q[i] <= '0;
            end
            kern_q    <= '0;
            kiss_q    <= '0;
            iss_q     <= 1'b0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
        end else begin
            if (i_valid) begin
                win_q[2] <= win_q[1];
                win_q[1] <= win_q[0];
                win_q[0] <= i_col;
            end
            if (i_kload) begin
                kern_q <= i_kernel;
            end
            // Snapshot taken before this edge's load, so a same-cycle i_kload is not seen.
            if (issue) begin
                kiss_q <= kern_q;
            end
            iss_q     <= issue;
            v1_q      <= iss_q;
            v2_q      <= v1_q;
            o_valid_q <= v2_q;
            if (v2_q) begin
                o_data_q <= BITS_DATA'(sat_shift(32'(total), SHIFT, BITS_DATA));
            end
        end
    end

    // Kernel column c pairs with window column 2-c (win_q[2] is the oldest).
    for (genvar r = 0; r < 3; r++) begin : g_row
        logic [3*BITS_IMAGEN-1:0] row_pix;
        logic [3*BITS_COEF-1:0]   row_coef;
        for (genvar c = 0; c < 3; c++) begin : g_col
            assign row_pix[c*BITS_IMAGEN +: BITS_IMAGEN] = win_q[2-c][(2-r)*BITS_IMAGEN +: BITS_IMAGEN];
            assign row_coef[c*BITS_COEF +: BITS_COEF]    = kiss_q[(8-(r*3+c))*BITS_COEF +: BITS_COEF];
        end
        conv_row_mac #(
            .BITS_IMAGEN (BITS_IMAGEN),
            .BITS_COEF   (BITS_COEF)
        ) u_row (
            .clk    (clk),
            .rst    (rst),
            .i_pix  (row_pix),
            .i_coef (row_coef),
            .o_sum  (row_sum[r])
        );
    end

    assign total = TOT_W'(row_sum[0]) + TOT_W'(row_sum[1]) + TOT_W'(row_sum[2]);

    assign o_data  = o_data_q;
    assign o_valid = o_valid_q;

endmodule
`default_nettype wire

// File: doc/conv_unit.md
Name: conv_unit

Overview:
- Downstream consumer of the MCU pixel-column bus: one 3x3 convolver lane.
- Takes one lane's 3-pixel column slice of the MCU's `o_DataConv`, keeps a 3-column sliding window, and multiplies it by a loadable signed 3x3 kernel.
- Returns one scaled, saturated `BITS_DATA` result per window; this drives one lane of the MCU's `i_DataConv`.
- N instances sit side by side between the MCU and its result path.

Parameters:
- BITS_IMAGEN, 8: unsigned pixel width.
- BITS_COEF, 8: signed kernel coefficient width.
- BITS_DATA, 13: signed output width.
- SHIFT, 7: arithmetic right shift applied to the full sum before saturation.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_col  in  3*BITS_IMAGEN  pixel column; row0 in MSBs, row2 in LSBs; unsigned.
- i_valid  in  1  column strobe; i_col is sampled when high.
- i_sop  in  1  start of new row/frame; restarts window fill.
- i_kernel  in  9*BITS_COEF  coefficients k[r][c]; k[0][0] in MSBs, row-major; signed.
- i_kload  in  1  latch i_kernel into the internal coefficient register.
- o_data  out  BITS_DATA  signed convolution result.
- o_valid  out  1  o_data valid for exactly this cycle.

Behaviour:
- Reset (rst=0, async): window columns, kernel register, pipeline, o_data and o_valid all clear to 0; FSM goes to IDLE. Reset mid-operation drops all in-flight results with no o_valid afterwards.
- Window:
  - win[0..2] is a 3-column shift register.
  - On i_valid: win[2]<=win[1], win[1]<=win[0], win[0]<=i_col.
  - win[2] is the oldest column and pairs with kernel column c=0.
- FSM states: IDLE, FILL, RUN; column counter cnt 0..2.
  - IDLE: i_valid or i_sop moves to FILL.
  - FILL: each i_valid increments cnt. The i_valid that brings the window to 3 columns moves to RUN and issues a window to the pipeline.
  - RUN: every i_valid issues a window (the updated window, including the new column).
  - i_sop in any state: cnt<=0, state goes to FILL. If i_valid is high in the same cycle, that column counts as the first (cnt<=1). Old columns are not used again.
  - i_sop does not flush the pipeline; results already issued still emerge.
- Pipeline, 3 register stages, fixed latency 3: the window issued at edge T gives o_valid=1 in the cycle after edge T+3.
  - S1: nine products, pixel zero-extended to signed BITS_IMAGEN+1 times coefficient. PROD_W = BITS_IMAGEN+BITS_COEF+1 (17).
  - S2: three row sums, PROD_W+2 bits.
  - S3: total sum, ACC_W = PROD_W+4 (21). Then arithmetic shift right by SHIFT, then saturate to signed BITS_DATA: clamp to [-2^(BITS_DATA-1), 2^(BITS_DATA-1)-1], i.e. [-4096, 4095].
- One window can be issued per cycle (i_valid every cycle gives one result per cycle). No back-pressure.
- o_data holds its last value when o_valid=0.
- Kernel:
  - i_kload latches at the edge.
  - A window issued in the same cycle as i_kload uses the old kernel. Windows issued later use the new kernel.
  - Results in flight are unaffected.
- i_valid=0 gaps: the window holds and nothing is issued.

Decomposition:
- Package conv_pkg holds:
  - width localparams PROD_W and ACC_W;
  - FSM state encoding IDLE/FILL/RUN;
  - a saturation function sat_shift(sum, SHIFT, BITS_DATA).
- Sub-module conv_row_mac: 3 multipliers plus row adder, registered at S1/S2. Instantiated 3 times; conv_unit does the final adder, saturation and FSM.

Test Plan (bench uses SHIFT=0 except where noted):
- Identity kernel (k[1][1]=1, rest 0), i_sop, then columns {10,20,30},{40,50,60},{70,80,90} on consecutive cycles -> single o_valid 3 cycles after the 3rd column, o_data=50. No o_valid after columns 1 and 2.
- Same kernel, 5 back-to-back columns -> 3 results on consecutive cycles: 50, then the centre of the next two windows.
- Saturation: all k=127, all pixels 255 -> 4095. All k=-128 -> -4096. SHIFT=7, k=127, pixels 255 -> (291465>>7)=2277.
- i_sop asserted with the 2nd column of a stream and i_valid high -> no result until 2 more columns. Results issued before i_sop still appear.
- i_kload switching kernel from identity to all-ones in the cycle a window issues -> that result uses identity, the next uses all-ones (sum of 9 pixels).
- rst low for one cycle while 2 results are in flight -> o_valid and o_data 0 immediately, no stale results. A fresh fill of 3 columns is required.
